// File: rtl/lvds_word_align.sv
// LVDS deserializer word-alignment controller: bitslip search for a training word.
// Optional slip statistics counter enabled by defining LVDS_ALIGN_STATS_EN.
module lvds_word_align #(
    parameter int              DATA_W        = 7,
    parameter logic [DATA_W-1:0] TRAIN_PATTERN = 7'b1100011,
    parameter int              SETTLE_CYCLES = 4,
    parameter int              MATCH_COUNT   = 16
) (
    input  logic              pclk,
    input  logic              reset,
    input  logic              locked,
    input  logic [DATA_W-1:0] din,
    input  logic              realign,
    output logic              bitslip,
    output logic              aligned,
    output logic              align_err,
    output logic [2:0]        slip_count,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic [15:0]       stat_slips
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int MW = $clog2(MATCH_COUNT + 1);
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
    localparam logic [MW-1:0] MATCH_LAST  = MW'(MATCH_COUNT - 1);
    localparam logic [2:0]    SLIP_LAST   = 3'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE, SETTLE, CHECK, SLIP, ALIGNED, FAIL
    } state_t;

    state_t          r_state;
    logic            r_lock_s1;
    logic            r_lock_s2;
    logic [SW-1:0]   r_settle_cnt;
    logic [MW-1:0]   r_match_cnt;
    logic            w_match;

    assign w_match = (din == TRAIN_PATTERN);

    always_ff @(posedge pclk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_lock_s1    <= 1'b0;
            r_lock_s2    <= 1'b0;
            r_settle_cnt <= '0;
            r_match_cnt  <= '0;
            bitslip      <= 1'b0;
            aligned      <= 1'b0;
            align_err    <= 1'b0;
            slip_count   <= '0;
            dout         <= '0;
            dout_valid   <= 1'b0;
        end else begin
            r_lock_s1 <= locked;
            r_lock_s2 <= r_lock_s1;
            dout      <= din;
            bitslip   <= 1'b0;
            // Lock loss overrides every state transition
            if (!r_lock_s2) begin
                r_state    <= IDLE;
                aligned    <= 1'b0;
                align_err  <= 1'b0;
                dout_valid <= 1'b0;
                slip_count <= '0;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        r_state      <= SETTLE;
                        r_settle_cnt <= SETTLE_LOAD;
                        slip_count   <= '0;
                    end
                    SETTLE: begin
                        if (r_settle_cnt == '0) begin
                            r_state     <= CHECK;
                            r_match_cnt <= '0;
                        end else begin
                            r_settle_cnt <= r_settle_cnt - 1'b1;
                        end
                    end
                    CHECK: begin
                        if (w_match) begin
                            if (r_match_cnt == MATCH_LAST) begin
                                r_state    <= ALIGNED;
                                aligned    <= 1'b1;
                                dout_valid <= 1'b1;
                            end else begin
                                r_match_cnt <= r_match_cnt + 1'b1;
                            end
                        end else if (slip_count < SLIP_LAST) begin
                            r_state    <= SLIP;
                            bitslip    <= 1'b1;
                            slip_count <= slip_count + 1'b1;
                        end else begin
                            r_state   <= FAIL;
                            align_err <= 1'b1;
                        end
                    end
                    SLIP: begin
                        r_state      <= SETTLE;
                        r_settle_cnt <= SETTLE_LOAD;
                    end
                    ALIGNED: begin
                        if (realign) begin
                            r_state      <= SETTLE;
                            r_settle_cnt <= SETTLE_LOAD;
                            slip_count   <= '0;
                            aligned      <= 1'b0;
                            dout_valid   <= 1'b0;
                        end
                    end
                    FAIL: begin
                        if (realign) begin
                            r_state      <= SETTLE;
                            r_settle_cnt <= SETTLE_LOAD;
                            slip_count   <= '0;
                            align_err    <= 1'b0;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

`ifdef LVDS_ALIGN_STATS_EN
    logic [15:0] r_stat_slips;

    // Counts registered pulses; survives lock loss and realign
    always_ff @(posedge pclk) begin
        if (reset) begin
            r_stat_slips <= '0;
        end else if (bitslip && (r_stat_slips != 16'hFFFF)) begin
            r_stat_slips <= r_stat_slips + 16'd1;
        end
    end

    assign stat_slips = r_stat_slips;
`else
    assign stat_slips = 16'h0000;
`endif

endmodule

// File: tb/tb_lvds_word_align.sv
// Self-checking bench for lvds_word_align with an ISERDES rotation model.
// Expected timings come from closed-form per-phase cycle costs.
module tb_lvds_word_align;

    localparam logic [6:0] PAT = 7'b1100011;
    localparam int SETTLE = 4;
    localparam int MATCH  = 16;
    // lock sync (2) + IDLE (1) + settle + matches
    localparam int T_ALIGN = 2 + 1 + SETTLE + MATCH;
    // CHECK mismatch + SLIP + settle
    localparam int T_SLIP  = 1 + 1 + SETTLE;

    logic        pclk;
    logic        reset;
    logic        locked;
    logic [6:0]  din;
    logic        realign;
    logic        bitslip;
    logic        aligned;
    logic        align_err;
    logic [2:0]  slip_count;
    logic [6:0]  dout;
    logic        dout_valid;
    logic [15:0] stat_slips;

    lvds_word_align dut (
        .pclk       (pclk),
        .reset      (reset),
        .locked     (locked),
        .din        (din),
        .realign    (realign),
        .bitslip    (bitslip),
        .aligned    (aligned),
        .align_err  (align_err),
        .slip_count (slip_count),
        .dout       (dout),
        .dout_valid (dout_valid),
        .stat_slips (stat_slips)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int checks = 0;
    int errors = 0;
    int cyc, pulses, last_pulse, min_gap;
    int dmode, rot, inj_cyc, stat_total;
    logic [6:0] din_fix;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] rotl(input logic [6:0] v, input int n);
        logic [13:0] d;
        d = {v, v} << n;
        return d[13:7];
    endfunction

    function automatic int exp_stat(input int n);
`ifdef LVDS_ALIGN_STATS_EN
        return n;
`else
        return 0;
`endif
    endfunction

    task automatic drive_din();
        if (dmode == 1) din = rotl(PAT, rot);
        else            din = din_fix;
        if (cyc == inj_cyc) din = 7'h00;
    endtask

    task automatic tick();
        logic [6:0] pre_din;
        logic       pre_rst;
        pre_din = din;
        pre_rst = reset;
        @(posedge pclk);
        #1;
        cyc++;
        if (!pre_rst) chk("dout_lag", dout, pre_din);
        if (bitslip) begin
            pulses++;
            stat_total++;
            if (last_pulse >= 0 && (cyc - last_pulse - 1) < min_gap)
                min_gap = cyc - last_pulse - 1;
            last_pulse = cyc;
            // each slip removes one rotation
            if (dmode == 1) rot = (rot + 6) % 7;
        end
        drive_din();
    endtask

    task automatic do_reset();
        locked  = 1'b0;
        realign = 1'b0;
        inj_cyc = -1;
        reset   = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        stat_total = 0;
    endtask

    task automatic start_lock();
        cyc        = 0;
        pulses     = 0;
        last_pulse = -1;
        min_gap    = 999;
        drive_din();
        locked = 1'b1;
    endtask

    // which: 0 aligned, 1 align_err, 2 bitslip
    task automatic wait_cond(input int which, input int bound, output int t);
        t = -1;
        for (int i = 0; i < bound; i++) begin
            tick();
            if ((which == 0 && aligned) || (which == 1 && align_err) ||
                (which == 2 && bitslip)) begin
                t = cyc;
                break;
            end
        end
    endtask

    initial begin
        int t, r, seen;
        reset = 1'b1; locked = 1'b0; realign = 1'b0; din = '0;
        dmode = 0; din_fix = PAT; rot = 0; inj_cyc = -1; cyc = 0;
        pulses = 0; last_pulse = -1; min_gap = 999; stat_total = 0;

        // reset state
        do_reset();
        chk("rst_bitslip", bitslip, 0);
        chk("rst_aligned", aligned, 0);
        chk("rst_err", align_err, 0);
        chk("rst_slipcnt", slip_count, 0);
        chk("rst_dout", dout, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_stat", stat_slips, 0);

        // lock gating
        din = PAT; seen = 0; pulses = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (aligned || dout_valid) seen = 1;
        end
        chk("gate_pulses", pulses, 0);
        chk("gate_seen", seen, 0);

        // pattern already aligned
        start_lock();
        wait_cond(0, 200, t);
        chk("al_time", t, T_ALIGN);
        chk("al_pulses", pulses, 0);
        chk("al_slipcnt", slip_count, 0);
        chk("al_valid", dout_valid, 1);

        // lock loss while aligned
        locked = 1'b0;
        tick(); tick(); tick();
        chk("ll_aligned", aligned, 0);
        chk("ll_valid", dout_valid, 0);
        chk("ll_slipcnt", slip_count, 0);
        start_lock();
        wait_cond(0, 200, t);
        chk("relock_time", t, T_ALIGN);

        // realign from ALIGNED keeps position
        cyc = 0;
        realign = 1'b1;
        tick();
        realign = 1'b0;
        chk("ra_aligned", aligned, 0);
        chk("ra_valid", dout_valid, 0);
        wait_cond(0, 200, t);
        chk("ra_time", t, 1 + SETTLE + MATCH);

        // rotated pattern, first case fixed at 3
        for (int k = 0; k < 5; k++) begin
            r = (k == 0) ? 3 : int'($urandom_range(1, 6));
            do_reset();
            dmode = 1; rot = r;
            start_lock();
            wait_cond(0, 400, t);
            chk("rot_time", t, T_ALIGN + T_SLIP * r);
            chk("rot_pulses", pulses, r);
            chk("rot_slipcnt", slip_count, r);
            chk("rot_gap_ok", (min_gap >= SETTLE + 1), 1);
            chk("rot_stat", stat_slips, exp_stat(r));
        end

        // pattern absent
        do_reset();
        dmode = 0; din_fix = 7'h00;
        start_lock();
        wait_cond(1, 400, t);
        chk("abs_time", t, 2 + 1 + SETTLE + 6 * T_SLIP + 1);
        chk("abs_pulses", pulses, 6);
        chk("abs_slipcnt", slip_count, 6);
        chk("abs_aligned", aligned, 0);
        for (int i = 0; i < 20; i++) tick();
        chk("abs_hold_err", align_err, 1);
        chk("abs_hold_pulses", pulses, 6);
        realign = 1'b1;
        tick();
        realign = 1'b0;
        chk("abs_ra_err", align_err, 0);
        chk("abs_ra_slipcnt", slip_count, 0);
        cyc = 0;
        wait_cond(2, 50, t);
        chk("abs_7th_time", t, SETTLE + 1);
        chk("abs_7th_pulses", pulses, 7);
        tick();
        chk("abs_stat", stat_slips, exp_stat(stat_total));

        // mismatch on 10th matching word in CHECK
        do_reset();
        dmode = 0; din_fix = PAT;
        inj_cyc = 2 + 1 + SETTLE + 9;
        start_lock();
        wait_cond(0, 200, t);
        chk("pm_time", t, T_ALIGN + 9 + T_SLIP);
        chk("pm_pulses", pulses, 1);
        chk("pm_slipcnt", slip_count, 1);

        // reset mid-SETTLE
        do_reset();
        din_fix = 7'h00;
        start_lock();
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1;
        tick();
        chk("rs_bitslip", bitslip, 0);
        chk("rs_aligned", aligned, 0);
        chk("rs_err", align_err, 0);
        chk("rs_slipcnt", slip_count, 0);
        chk("rs_dout", dout, 0);
        chk("rs_valid", dout_valid, 0);
        chk("rs_stat", stat_slips, 0);
        reset = 1'b0;
        locked = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lvds_word_align.md
Name: lvds_word_align

Overview:
- Deserializer word-alignment controller in the parallel clock domain (pclk, 1/7 of the LVDS bit clock).
- Sits directly downstream of the LVDS clock generator. Waits for the PLL/MMCM lock, then inspects 7-bit parallel words from the ISERDES.
- Issues single-cycle bitslip pulses until the training pattern is seen continuously. Once aligned, forwards the aligned data with a valid flag.

Parameters:
- DATA_W, 7, parallel word width. Also the number of distinct bitslip positions.
- TRAIN_PATTERN, 7'b1100011, word expected on the LVDS channel during training.
- SETTLE_CYCLES, 4, pclk cycles to wait after each bitslip (and after lock) before checking data; must be ≥1.
- MATCH_COUNT, 16, consecutive matching words required to declare alignment; must be ≥1.

Ports:
- pclk  input  1  parallel clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- locked  input  1  PLL/MMCM lock; asynchronous to pclk.
- din  input  DATA_W  parallel word from the ISERDES.
- realign  input  1  single-cycle request to restart the alignment search.
- bitslip  output  1  one-cycle pulse to the ISERDES BITSLIP pin.
- aligned  output  1  high while in state ALIGNED.
- align_err  output  1  high while in state FAIL.
- slip_count  output  3  number of bitslips issued in the current search.
- dout  output  DATA_W  registered din.
- dout_valid  output  1  qualifies dout.
- stat_slips  output  16  total bitslips counter (see Optional Feature).

Behaviour:
- Reset values:
  - bitslip=0, aligned=0, align_err=0, slip_count=0, dout=0, dout_valid=0, stat_slips=0.
  - Both lock synchroniser flops = 0; state = IDLE.
- Lock synchroniser: two-flop chain produces locked_s. locked_s lags locked by 2 cycles.
- locked_s=0 in any state:
  - Next state is IDLE.
  - aligned, align_err, dout_valid, bitslip and slip_count go to 0 on the same edge.
  - Takes priority over every other transition except reset.
- IDLE: when locked_s=1, go to SETTLE. Load settle_cnt=SETTLE_CYCLES-1 and clear slip_count.
- SETTLE:
  - Decrement settle_cnt each cycle.
  - When settle_cnt=0, go to CHECK and clear match_cnt. Data in SETTLE is ignored.
- CHECK, every cycle, compare din against TRAIN_PATTERN:
  - Match and match_cnt=MATCH_COUNT-1: go to ALIGNED.
  - Match otherwise: match_cnt+1.
  - Mismatch and slip_count<DATA_W-1: go to SLIP.
  - Mismatch and slip_count=DATA_W-1: go to FAIL.
- SLIP:
  - bitslip=1 for exactly this one cycle; slip_count+1.
  - Next state is SETTLE with settle_cnt reloaded.
  - Consecutive bitslip pulses are therefore separated by ≥SETTLE_CYCLES+1 low cycles.
- ALIGNED:
  - aligned=1; no pattern monitoring.
  - realign=1 goes to SETTLE with slip_count=0; the ISERDES position is kept.
- FAIL:
  - align_err=1; stays in FAIL until realign, locked loss or reset.
  - realign goes to SETTLE with slip_count=0, and align_err drops on the same edge.
- realign in IDLE, SETTLE, CHECK or SLIP is ignored.
- Outputs aligned and align_err are registered from the state and change on the same edge as the transition.
- Datapath:
  - dout <= din every cycle; 1-cycle latency.
  - dout_valid <= 1 when the next state is ALIGNED, so dout_valid rises on the same edge as aligned.
  - dout_valid=0 on every exit from ALIGNED.
- Widths:
  - settle_cnt is $clog2(SETTLE_CYCLES+1) bits; match_cnt is $clog2(MATCH_COUNT+1) bits.
  - slip_count never exceeds DATA_W-1 and never wraps.

Optional Feature:
- Macro: LVDS_ALIGN_STATS_EN.
- Defined: stat_slips increments on every bitslip pulse, saturates at 16'hFFFF, and is cleared only by reset. Locked loss and realign do not clear it.
- Undefined: stat_slips is tied to 16'h0000 and no counter logic is built. The port list is unchanged.

Test Plan:
- Lock gating: locked=0, din=7'b1100011 for 100 cycles, with the defaults → bitslip never pulses; aligned=0, dout_valid=0.
- Pattern already aligned: din=7'b1100011 and locked rises at cycle 0 → aligned rises at cycle 2+1+4+16 (±1 per sync edge). Zero bitslip pulses; slip_count=0; dout tracks din with 1-cycle lag.
- Rotated pattern: ISERDES model rotates by 3 positions, with one rotation removed per bitslip → exactly 3 pulses, each ≥5 cycles apart. Ends with slip_count=3, aligned=1; stat_slips=3 with LVDS_ALIGN_STATS_EN.
- Pattern absent: din=0 → exactly 6 bitslip pulses, then align_err=1, aligned=0. A realign pulse clears align_err next edge and restarts the search (a 7th pulse appears; stat_slips=7 with the macro).
- Partial match: a mismatch injected on the 10th matching word in CHECK → one bitslip, match_cnt restarts, and ≥16 further matches are needed before aligned.
- Lock loss / reset: locked drops while aligned → aligned and dout_valid are 0 within 3 cycles and the state is IDLE; re-lock realigns. reset asserted mid-SETTLE → all outputs at reset values on the next edge.
